// File: rtl/axo_dma_copy.sv
// axo_dma_copy: axo memory-bus block copy engine, one read then one write per aligned unit.
// Define AXO_DMA_FILL_EN to add a pattern-fill mode that skips reads.
module axo_dma_copy #(
  parameter int lbits = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [31:0]      src_addr_i,
  input  logic [31:0]      dst_addr_i,
  input  logic [lbits-1:0] len_i,
`ifdef AXO_DMA_FILL_EN
  input  logic             fill_i,
  input  logic [31:0]      fill_data_i,
`endif
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [31:0]      err_addr_o,
  output logic [31:0]      err_code_o,
  output logic [31:0]      bus_addr_o,
  output logic [1:0]       bus_asize_o,
  output logic             bus_re_o,
  output logic             bus_we_o,
  output logic [31:0]      bus_wdata_o,
  input  logic [31:0]      bus_rdata_i,
  input  logic             bus_ready_i,
  input  logic             bus_error_i
);
  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
  state_t state_q, state_d;
  logic [31:0] src_q, src_d, dst_q, dst_d, buf_q, buf_d;
  logic [31:0] err_addr_q, err_addr_d, err_code_q, err_code_d;
  logic [lbits-1:0] rem_q, rem_d, step;
  logic done_q, done_d, err_q, err_d, fill_q, fill_start;
  logic [31:0] fdata_q, mask;
  logic [1:0] lo, asize;
`ifdef AXO_DMA_FILL_EN
  assign fill_start = fill_i;
  always_ff @(posedge clk)
    if (rst) begin
      fill_q <= 1'b0;
      fdata_q <= '0;
    end else if (state_q == IDLE && start_i) begin
      fill_q <= fill_i;
      fdata_q <= fill_data_i;
    end
`else
  assign fill_start = 1'b0;
  assign fill_q = 1'b0;
  assign fdata_q = '0;
`endif
  // Widest unit keeping src, dst and the remaining count aligned; fill has no src
  assign lo = (fill_q ? 2'b00 : src_q[1:0]) | dst_q[1:0] | rem_q[1:0];
  assign asize = lo == 2'b00 ? 2'd2 : !lo[0] ? 2'd1 : 2'd0;
  assign step = lbits'(1) << asize;
  assign mask = asize == 2'd2 ? 32'hffff_ffff : asize == 2'd1 ? 32'h0000_ffff : 32'h0000_00ff;
  assign busy_o = state_q != IDLE;
  assign done_o = done_q;
  assign err_o = err_q;
  assign err_addr_o = err_addr_q;
  assign err_code_o = err_code_q;
  assign bus_addr_o = state_q == WRITE ? dst_q : src_q;
  assign bus_asize_o = asize;
  assign bus_re_o = state_q == READ && !rst;
  assign bus_we_o = state_q == WRITE && !rst;
  assign bus_wdata_o = !fill_q ? buf_q : asize == 2'd2 ? fdata_q :
                       asize == 2'd1 ? {2{fdata_q[15:0]}} : {4{fdata_q[7:0]}};
  always_comb begin
    state_d = state_q;
    src_d = src_q;
    dst_d = dst_q;
    rem_d = rem_q;
    buf_d = buf_q;
    done_d = 1'b0;
    err_d = err_q;
    err_addr_d = err_addr_q;
    err_code_d = err_code_q;
    case (state_q)
      IDLE: if (start_i) begin
        err_d = 1'b0;
        done_d = len_i == '0;
        src_d = src_addr_i;
        dst_d = dst_addr_i;
        rem_d = len_i;
        state_d = len_i == '0 ? IDLE : fill_start ? WRITE : READ;
      end
      default: if (bus_ready_i) begin
        if (bus_error_i) begin
          err_d = 1'b1;
          err_addr_d = bus_addr_o;
          err_code_d = bus_rdata_i;
          state_d = IDLE;
        end else if (state_q == READ) begin
          buf_d = bus_rdata_i & mask;
          state_d = WRITE;
        end else begin
          src_d = src_q + 32'(step);
          dst_d = dst_q + 32'(step);
          rem_d = rem_q - step;
          done_d = rem_q == step;
          state_d = rem_q == step ? IDLE : fill_q ? WRITE : READ;
        end
      end
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      src_q <= '0;
      dst_q <= '0;
      rem_q <= '0;
      buf_q <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      err_addr_q <= '0;
      err_code_q <= '0;
    end else begin
      state_q <= state_d;
      src_q <= src_d;
      dst_q <= dst_d;
      rem_q <= rem_d;
      buf_q <= buf_d;
      done_q <= done_d;
      err_q <= err_d;
      err_addr_q <= err_addr_d;
      err_code_q <= err_code_d;
    end
endmodule
